// File: rtl/word_byte_writer.sv
// Splits a 16-bit store into two byte writes on the 8-bit memory bus:
// high byte at the base address, then low byte at base+1, with wait states and a timeout abort.
module word_byte_writer #(
   parameter int ADDR_W  = 13,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       word_in,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ovf,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_wr,
   input  logic              mem_rdy
);

   // state | meaning
   // IDLE  | waiting for start
   // HI    | high byte on the bus at base address
   // LO    | low byte on the bus at base+1
   // DONE  | one-cycle done pulse
   // ABORT | one-cycle err pulse after a timeout
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HI    = 3'd1,
      S_LO    = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   state_t              state_q;
   logic [15:0]         word_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                busy_q, done_q, err_q, ovf_q, mem_wr_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [7:0]          mem_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (start && state_q != S_IDLE)
            ovf_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  word_q     <= word_in;
                  addr_q     <= addr_in;
                  mem_addr_q <= addr_in;
                  mem_data_q <= word_in[15:8];
                  mem_wr_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= S_HI;
               end else begin
                  mem_wr_q <= 1'b0;
               end
            end
            S_HI: begin
               if (mem_wr_q && mem_rdy) begin
                  mem_addr_q <= addr_q + ADDR_W'(1);
                  mem_data_q <= word_q[7:0];
                  cnt_q      <= '0;
                  state_q    <= S_LO;
               end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                  mem_wr_q <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_ABORT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_LO: begin
               if (mem_wr_q && mem_rdy) begin
                  mem_wr_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                  mem_wr_q <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_ABORT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE, S_ABORT: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               mem_wr_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign ovf      = ovf_q;
   assign mem_wr   = mem_wr_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;

endmodule

// File: tb/tb_word_byte_writer.sv
// Directed bench for word_byte_writer: byte ordering, wait states, address wrap,
// timeout abort, overflow flag and asynchronous reset mid-transfer.
module tb_word_byte_writer;

   localparam int ADDR_W  = 13;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [15:0]       word_in;
   logic [ADDR_W-1:0] addr_in;
   logic              busy, done, err, ovf;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_wr;
   logic              mem_rdy;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt, err_cnt, wr_cycles;
   logic [31:0] wq[$];

   word_byte_writer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .word_in(word_in), .addr_in(addr_in),
      .busy(busy), .done(done), .err(err), .ovf(ovf),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_rdy(mem_rdy)
   );

   always #5 clk = ~clk;

   // bus-side observer: accepted writes and pulse counts
   always @(posedge clk) begin
      if (!rst) begin
         if (mem_wr && mem_rdy) wq.push_back({11'd0, mem_addr, mem_data});
         if (mem_wr) wr_cycles++;
         if (done) done_cnt++;
         if (err) err_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      wq.delete();
      done_cnt  = 0;
      err_cnt   = 0;
      wr_cycles = 0;
   endtask

   function automatic logic [31:0] wr_at(input int i);
      if (i < wq.size()) return wq[i];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic do_start(input logic [15:0] w, input logic [ADDR_W-1:0] a);
      start   = 1'b1;
      word_in = w;
      addr_in = a;
      step();
      start   = 1'b0;
      word_in = 16'h0000;
      addr_in = '0;
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; word_in = '0; addr_in = '0; mem_rdy = 1'b0;
      clear_obs();
      run_idle(2);
      check("rst_busy", busy, 0);
      check("rst_wr", mem_wr, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      check("rst_ovf", ovf, 0);
      #2 rst = 1'b0;
      step();

      // 1: back-to-back writes, mem_rdy held high
      mem_rdy = 1'b1;
      clear_obs();
      do_start(16'hA55A, 13'h0100);
      check("s1_busy", busy, 1);
      check("s1_hi_wr", mem_wr, 1);
      check("s1_hi_addr", mem_addr, 13'h0100);
      check("s1_hi_data", mem_data, 8'hA5);
      step();
      check("s1_lo_addr", mem_addr, 13'h0101);
      check("s1_lo_data", mem_data, 8'h5A);
      check("s1_lo_wr", mem_wr, 1);
      step();
      check("s1_done", done, 1);
      check("s1_done_wr", mem_wr, 0);
      step();
      check("s1_done_once", done, 0);
      check("s1_busy_end", busy, 0);
      run_idle(2);
      check("s1_nwr", wq.size(), 2);
      check("s1_w0", wr_at(0), {11'd0, 13'h0100, 8'hA5});
      check("s1_w1", wr_at(1), {11'd0, 13'h0101, 8'h5A});
      check("s1_done_cnt", done_cnt, 1);
      check("s1_err_cnt", err_cnt, 0);

      // 2: wait states, 3 in HI and 2 in LO
      mem_rdy = 1'b0;
      clear_obs();
      do_start(16'hA55A, 13'h0100);
      for (int i = 0; i < 3; i++) begin
         step();
         check("s2_hi_hold_addr", mem_addr, 13'h0100);
         check("s2_hi_hold_data", mem_data, 8'hA5);
         check("s2_hi_hold_wr", mem_wr, 1);
      end
      mem_rdy = 1'b1;
      step();
      mem_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("s2_lo_hold_addr", mem_addr, 13'h0101);
         check("s2_lo_hold_data", mem_data, 8'h5A);
         check("s2_lo_hold_wr", mem_wr, 1);
      end
      mem_rdy = 1'b1;
      run_idle(4);
      check("s2_nwr", wq.size(), 2);
      check("s2_w0", wr_at(0), {11'd0, 13'h0100, 8'hA5});
      check("s2_w1", wr_at(1), {11'd0, 13'h0101, 8'h5A});
      check("s2_done_cnt", done_cnt, 1);
      check("s2_err_cnt", err_cnt, 0);

      // 3: base address wraps to 0
      clear_obs();
      do_start(16'h1234, 13'h1FFF);
      run_idle(4);
      check("s3_w0", wr_at(0), {11'd0, 13'h1FFF, 8'h12});
      check("s3_w1", wr_at(1), {11'd0, 13'h0000, 8'h34});
      check("s3_done_cnt", done_cnt, 1);

      // 4: timeout in HI, then a normal transfer
      mem_rdy = 1'b0;
      clear_obs();
      do_start(16'hCAFE, 13'h0040);
      for (int n = 0; n < 40 && !err; n++) step();
      check("s4_err_seen", err, 1);
      check("s4_wr_cycles", wr_cycles, TIMEOUT + 1);
      check("s4_abort_wr", mem_wr, 0);
      step();
      check("s4_err_once", err, 0);
      check("s4_busy_end", busy, 0);
      run_idle(2);
      check("s4_err_cnt", err_cnt, 1);
      check("s4_done_cnt", done_cnt, 0);
      check("s4_nwr", wq.size(), 0);
      mem_rdy = 1'b1;
      clear_obs();
      do_start(16'h00FF, 13'h0200);
      run_idle(4);
      check("s4_re_w0", wr_at(0), {11'd0, 13'h0200, 8'h00});
      check("s4_re_w1", wr_at(1), {11'd0, 13'h0201, 8'hFF});
      check("s4_re_done", done_cnt, 1);

      // 5: start during HI is ignored but flagged
      mem_rdy = 1'b0;
      clear_obs();
      check("s5_ovf_pre", ovf, 0);
      do_start(16'hBEEF, 13'h0300);
      do_start(16'h1111, 13'h0555);
      check("s5_ovf_set", ovf, 1);
      check("s5_hold_data", mem_data, 8'hBE);
      mem_rdy = 1'b1;
      run_idle(5);
      check("s5_w0", wr_at(0), {11'd0, 13'h0300, 8'hBE});
      check("s5_w1", wr_at(1), {11'd0, 13'h0301, 8'hEF});
      check("s5_nwr", wq.size(), 2);
      check("s5_ovf_sticky", ovf, 1);

      // 6: async reset during LO
      mem_rdy = 1'b0;
      clear_obs();
      do_start(16'h5678, 13'h0010);
      mem_rdy = 1'b1;
      step();
      mem_rdy = 1'b0;
      check("s6_in_lo", mem_addr, 13'h0011);
      #2 rst = 1'b1;
      #1;
      check("s6_rst_wr", mem_wr, 0);
      check("s6_rst_busy", busy, 0);
      check("s6_rst_ovf", ovf, 0);
      run_idle(2);
      #2 rst = 1'b0;
      run_idle(2);
      check("s6_no_done", done_cnt, 0);
      check("s6_no_err", err_cnt, 0);
      mem_rdy = 1'b1;
      clear_obs();
      do_start(16'hA55A, 13'h0100);
      check("s6_re_data", mem_data, 8'hA5);
      run_idle(4);
      check("s6_re_w0", wr_at(0), {11'd0, 13'h0100, 8'hA5});
      check("s6_re_w1", wr_at(1), {11'd0, 13'h0101, 8'h5A});
      check("s6_re_done", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
